tx_frame_feeder: RTL and testbench

TX_FRAME_FEEDER -- requirements
Module: tx_frame_feeder

---
 rtl/tx_frame_feeder.sv | 118 +++++++++++
 tb/tb_tx_frame_feeder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_feeder.sv
// Feeds a downstream width converter: user words pass through a 2-entry FIFO and
// are presented on dout for RATIO cycles each, with IDLE_WORD filling underruns.
module tx_frame_feeder #(
  parameter int unsigned        DWIDTH    = 256,
  parameter int unsigned        RATIO     = 4,
  parameter int unsigned        CNT_WIDTH = 2,
  parameter logic [DWIDTH-1:0]  IDLE_WORD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DWIDTH-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [DWIDTH-1:0]    dout,
  output logic                 dout_is_data,
  output logic                 dout_last
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(RATIO - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef logic [DWIDTH:0] entry_t;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 load;

  entry_t               mem_q [2];
  entry_t               mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 tready_q, tready_d;
  logic                 push, pop;

  logic [DWIDTH-1:0]    dout_q, dout_d;
  logic                 is_data_q, is_data_d;
  logic                 last_q, last_d;

  // A load edge is the 0->1 counter step; with RATIO == 1 every edge loads.
  always_comb begin
    if (RATIO == 1) begin
      cnt_d = CNT_ONE;
      load  = 1'b1;
    end else begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
      load  = (cnt_q == '0);
    end
  end

  assign push = s_axis_tvalid && tready_q;
  assign pop  = load && (count_q != 2'd0);

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {s_axis_tlast, s_axis_tdata};
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    // Registered from the post-edge occupancy, so a full FIFO drops tready for
    // one cycle even when a pop frees a slot on the same edge.
    tready_d = (count_d != 2'd2);
  end

  always_comb begin
    dout_d    = dout_q;
    is_data_d = is_data_q;
    last_d    = last_q;
    if (load) begin
      if (pop) begin
        dout_d    = mem_q[rd_ptr_q][DWIDTH-1:0];
        last_d    = mem_q[rd_ptr_q][DWIDTH];
        is_data_d = 1'b1;
      end else begin
        dout_d    = IDLE_WORD;
        last_d    = 1'b0;
        is_data_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      tready_q  <= 1'b0;
      dout_q    <= IDLE_WORD;
      is_data_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tready_q  <= tready_d;
      dout_q    <= dout_d;
      is_data_q <= is_data_d;
      last_q    <= last_d;
    end
  end

  // Storage needs no reset: pointers and occupancy gate every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign s_axis_tready = tready_q;
  assign cnt           = cnt_q;
  assign dout          = dout_q;
  assign dout_is_data  = is_data_q;
  assign dout_last     = last_q;

endmodule

// File: tb/tb_tx_frame_feeder.sv
// Directed bench for tx_frame_feeder: a RATIO=4 instance and a RATIO=1 instance.
module tb_tx_frame_feeder;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, tvalid_a, tlast_a, tready_a, is_data_a, last_a;
  logic [255:0] tdata_a, dout_a;
  logic [1:0]   cnt_a;

  logic         rst_b, tvalid_b, tlast_b, tready_b, is_data_b, last_b;
  logic [255:0] tdata_b, dout_b;
  logic [1:0]   cnt_b;

  tx_frame_feeder #(.DWIDTH(256), .RATIO(4), .CNT_WIDTH(2), .IDLE_WORD('0)) u_a (
    .clk(clk), .rst(rst_a),
    .s_axis_tdata(tdata_a), .s_axis_tvalid(tvalid_a), .s_axis_tlast(tlast_a),
    .s_axis_tready(tready_a), .cnt(cnt_a), .dout(dout_a),
    .dout_is_data(is_data_a), .dout_last(last_a)
  );

  tx_frame_feeder #(.DWIDTH(256), .RATIO(1), .CNT_WIDTH(2), .IDLE_WORD('0)) u_b (
    .clk(clk), .rst(rst_b),
    .s_axis_tdata(tdata_b), .s_axis_tvalid(tvalid_b), .s_axis_tlast(tlast_b),
    .s_axis_tready(tready_b), .cnt(cnt_b), .dout(dout_b),
    .dout_is_data(is_data_b), .dout_last(last_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned next_w;
  logic        accept;
  logic        exp_rdy;
  logic [255:0] words_b [3];

  initial begin
    rst_a = 1'b1; tvalid_a = 1'b0; tlast_a = 1'b0; tdata_a = '0;
    rst_b = 1'b1; tvalid_b = 1'b0; tlast_b = 1'b0; tdata_b = '0;
    repeat (3) step();

    // Reset state
    check_eq("rst_cnt",     256'(cnt_a),     256'(0));
    check_eq("rst_tready",  256'(tready_a),  256'(0));
    check_eq("rst_dout",    dout_a,          256'(0));
    check_eq("rst_is_data", 256'(is_data_a), 256'(0));
    check_eq("rst_last",    256'(last_a),    256'(0));
    check_eq("rst_b_cnt",   256'(cnt_b),     256'(0));
    check_eq("rst_b_tready",256'(tready_b),  256'(0));

    // Idle run after reset release: cnt 1,2,3,0,...
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("idle_cnt",     256'(cnt_a),     256'((i + 1) % 4));
      check_eq("idle_tready",  256'(tready_a),  256'(1));
      check_eq("idle_is_data", 256'(is_data_a), 256'(0));
      check_eq("idle_dout",    dout_a,          256'(0));
    end

    // Single word accepted while cnt == 2
    step();
    step();
    check_eq("single_pre_cnt", 256'(cnt_a), 256'(2));
    tvalid_a = 1'b1; tdata_a = 256'h0A5; tlast_a = 1'b1;
    step();
    tvalid_a = 1'b0; tlast_a = 1'b0;
    check_eq("single_no_bypass", 256'(is_data_a), 256'(0));
    step();
    step();
    check_eq("single_load_cnt", 256'(cnt_a),     256'(1));
    check_eq("single_dout",     dout_a,          256'h0A5);
    check_eq("single_is_data",  256'(is_data_a), 256'(1));
    check_eq("single_last",     256'(last_a),    256'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("single_hold_dout", dout_a,        256'h0A5);
      check_eq("single_hold_last", 256'(last_a),  256'(1));
    end
    step();
    check_eq("single_after_dout",    dout_a,          256'(0));
    check_eq("single_after_is_data", 256'(is_data_a), 256'(0));
    check_eq("single_after_last",    256'(last_a),    256'(0));

    // Word accepted on the load edge itself with an empty FIFO
    repeat (3) step();
    check_eq("onload_pre_cnt", 256'(cnt_a), 256'(0));
    tvalid_a = 1'b1; tdata_a = 256'h05C; tlast_a = 1'b0;
    step();
    tvalid_a = 1'b0;
    check_eq("onload_now_is_data", 256'(is_data_a), 256'(0));
    check_eq("onload_now_dout",    dout_a,          256'(0));
    repeat (4) step();
    check_eq("onload_later_dout",    dout_a,          256'h05C);
    check_eq("onload_later_is_data", 256'(is_data_a), 256'(1));
    check_eq("onload_later_last",    256'(last_a),    256'(0));

    // Continuous stream of words 1..10, tlast on word 10
    next_w = 1;
    for (int p = 1; p <= 11; p++) begin
      for (int j = 0; j < 4; j++) begin
        exp_rdy = (p == 1) ? (j < 2) : (p >= 10) ? 1'b1 : (j == 0);
        check_eq("stream_tready", 256'(tready_a), 256'(exp_rdy));
        tvalid_a = (next_w <= 10);
        tdata_a  = 256'(next_w);
        tlast_a  = (next_w == 10);
        accept   = tvalid_a && tready_a;
        step();
        if (accept) next_w++;
      end
      check_eq("stream_dout",    dout_a,          (p <= 10) ? 256'(p) : 256'(0));
      check_eq("stream_is_data", 256'(is_data_a), 256'(p <= 10));
      check_eq("stream_last",    256'(last_a),    256'(p == 10));
    end
    tvalid_a = 1'b0; tlast_a = 1'b0;
    check_eq("stream_accepted", 256'(next_w), 256'(11));

    // Reset mid-operation with a word presented and the FIFO full
    tvalid_a = 1'b1; tdata_a = 256'h111;
    step();
    tdata_a = 256'h222;
    step();
    tvalid_a = 1'b0;
    check_eq("full_tready", 256'(tready_a), 256'(0));
    step();
    step();
    check_eq("prefill_dout", dout_a, 256'h111);
    tvalid_a = 1'b1; tdata_a = 256'h333;
    step();
    tvalid_a = 1'b0;
    check_eq("prefill_full_tready", 256'(tready_a), 256'(0));
    rst_a = 1'b1;
    step();
    check_eq("midrst_cnt",     256'(cnt_a),     256'(0));
    check_eq("midrst_tready",  256'(tready_a),  256'(0));
    check_eq("midrst_dout",    dout_a,          256'(0));
    check_eq("midrst_is_data", 256'(is_data_a), 256'(0));
    rst_a = 1'b0;
    step();
    check_eq("postrst_cnt",    256'(cnt_a),    256'(1));
    check_eq("postrst_tready", 256'(tready_a), 256'(1));
    for (int k = 0; k < 2; k++) begin
      repeat (4) step();
      check_eq("postrst_is_data", 256'(is_data_a), 256'(0));
      check_eq("postrst_dout",    dout_a,          256'(0));
    end

    // RATIO=1 instance: load every cycle, three back-to-back words
    words_b[0] = 256'h11; words_b[1] = 256'h22; words_b[2] = 256'h33;
    rst_b = 1'b0;
    step();
    check_eq("r1_first_cnt",    256'(cnt_b),    256'(1));
    check_eq("r1_first_tready", 256'(tready_b), 256'(1));
    check_eq("r1_first_dout",   dout_b,         256'(0));
    for (int k = 0; k < 5; k++) begin
      tvalid_b = (k < 3);
      tdata_b  = (k < 3) ? words_b[k] : '0;
      tlast_b  = (k == 2);
      step();
      check_eq("r1_cnt",    256'(cnt_b),    256'(1));
      check_eq("r1_tready", 256'(tready_b), 256'(1));
      check_eq("r1_dout",   dout_b,         (k >= 1 && k <= 3) ? words_b[k-1] : 256'(0));
      check_eq("r1_is_data",256'(is_data_b),256'(k >= 1 && k <= 3));
      check_eq("r1_last",   256'(last_b),   256'(k == 3));
    end
    tvalid_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
